// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one memory port, one transaction outstanding at a time.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise the data port wins ties.
module mem_port_arbiter (
  input  logic        soc_clk,
  input  logic        resetn,
  input  logic        i_req,
  input  logic [63:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [63:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [7:0]  d_wstrb,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [63:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [7:0]  m_wstrb,
  output logic [63:0] m_addr,
  output logic [63:0] m_wdata,
  input  logic        m_gnt,
  input  logic        m_rvalid,
  input  logic [63:0] m_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [7:0]  wstrb_q, wstrb_d;
  logic        pick_data;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic        last_data_q, last_data_d;

  // On a tie the port that did not win last time goes next.
  always_comb begin
    pick_data = d_req && (!i_req || !last_data_q);
  end
`else
  always_comb begin
    pick_data = d_req;
  end
`endif

  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;
  assign m_addr  = addr_q;
  assign m_we    = we_q;
  assign m_wstrb = wstrb_q;
  assign m_wdata = wdata_q;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    wstrb_d  = wstrb_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_data_d = last_data_q;
`endif
    i_gnt    = 1'b0;
    d_gnt    = 1'b0;
    i_rvalid = 1'b0;
    d_rvalid = 1'b0;
    m_req    = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          i_gnt   = !pick_data;
          d_gnt   = pick_data;
          owner_d = pick_data;
          state_d = ISSUE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_data_d = pick_data;
`endif
          if (pick_data) begin
            addr_d  = d_addr;
            we_d    = d_we;
            wstrb_d = d_we ? d_wstrb : 8'h00;
            wdata_d = d_wdata;
          end else begin
            addr_d  = i_addr;
            we_d    = 1'b0;
            wstrb_d = 8'h00;
            wdata_d = 64'h0;
          end
        end
      end
      ISSUE: begin
        m_req = 1'b1;
        if (m_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (m_rvalid) begin
          i_rvalid = !owner_q;
          d_rvalid = owner_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset overrides everything, including the combinational handshakes.
    if (!resetn) begin
      i_gnt    = 1'b0;
      d_gnt    = 1'b0;
      i_rvalid = 1'b0;
      d_rvalid = 1'b0;
      m_req    = 1'b0;
    end
  end

  always_ff @(posedge soc_clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      addr_q  <= 64'h0;
      wdata_q <= 64'h0;
      we_q    <= 1'b0;
      wstrb_q <= 8'h00;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_data_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      wstrb_q <= wstrb_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_data_q <= last_data_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic with resets and spurious responses.
module tb_mem_port_arbiter;

  logic        soc_clk = 1'b0;
  logic        resetn;
  logic        i_req, i_gnt, i_rvalid;
  logic [63:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [7:0]  d_wstrb;
  logic [63:0] d_addr, d_wdata, d_rdata;
  logic        m_req, m_we, m_gnt, m_rvalid;
  logic [7:0]  m_wstrb;
  logic [63:0] m_addr, m_wdata, m_rdata;

  always #5 soc_clk = ~soc_clk;

  mem_port_arbiter dut (
    .soc_clk(soc_clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one outstanding transaction record, plus whether memory has taken it.
  logic        busy = 1'b0, sent = 1'b0, own = 1'b0;
  logic [63:0] t_addr = 64'h0, t_wdata = 64'h0;
  logic        t_we = 1'b0;
  logic [7:0]  t_wstrb = 8'h00;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic        last_data = 1'b0;
`endif
  logic        exp_i_gnt = 1'b0, exp_d_gnt = 1'b0;
  logic        dut_log[$];

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_word(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_output();
    logic win_data, em_req, ei_rv, ed_rv;
    #1;
    exp_i_gnt = 1'b0; exp_d_gnt = 1'b0;
    em_req = 1'b0; ei_rv = 1'b0; ed_rv = 1'b0;
    if (resetn) begin
      if (!busy) begin
        if (i_req && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          win_data = !last_data;
`else
          win_data = 1'b1;
`endif
        end else begin
          win_data = d_req;
        end
        exp_d_gnt = d_req && win_data;
        exp_i_gnt = i_req && !win_data;
      end else if (!sent) begin
        em_req = 1'b1;
      end else if (m_rvalid) begin
        ei_rv = !own;
        ed_rv = own;
      end
    end
    if (i_gnt || d_gnt) dut_log.push_back(d_gnt);
    check_bit("i_gnt", i_gnt, exp_i_gnt);
    check_bit("d_gnt", d_gnt, exp_d_gnt);
    check_bit("m_req", m_req, em_req);
    check_bit("i_rvalid", i_rvalid, ei_rv);
    check_bit("d_rvalid", d_rvalid, ed_rv);
    if (em_req) begin
      check_word("m_addr", m_addr, t_addr);
      check_bit("m_we", m_we, t_we);
      check_word("m_wstrb", {56'h0, m_wstrb}, {56'h0, t_wstrb});
      if (t_we) check_word("m_wdata", m_wdata, t_wdata);
    end
    if (ei_rv) check_word("i_rdata", i_rdata, m_rdata);
    if (ed_rv && !t_we) check_word("d_rdata", d_rdata, m_rdata);
  endtask

  task automatic advance();
    @(posedge soc_clk);
    if (!resetn) begin
      busy = 1'b0;
      sent = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_data = 1'b0;
`endif
    end else if (!busy) begin
      if (exp_i_gnt || exp_d_gnt) begin
        busy = 1'b1;
        sent = 1'b0;
        own  = exp_d_gnt;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_data = exp_d_gnt;
`endif
        if (exp_d_gnt) begin
          t_addr = d_addr; t_we = d_we; t_wdata = d_wdata;
          t_wstrb = d_we ? d_wstrb : 8'h00;
        end else begin
          t_addr = i_addr; t_we = 1'b0; t_wdata = 64'h0; t_wstrb = 8'h00;
        end
      end
    end else if (!sent) begin
      if (m_gnt) sent = 1'b1;
    end else if (m_rvalid) begin
      busy = 1'b0;
    end
    @(negedge soc_clk);
  endtask

  task automatic step();
    check_output();
    advance();
  endtask

  task automatic quiet_inputs();
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wstrb = 8'h00;
    m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = 64'h0;
  endtask

  // Random traffic: requests are held until granted, memory stalls and spurious responses occur.
  task automatic apply_stimulus();
    if (exp_i_gnt) i_req = 1'b0;
    if (exp_d_gnt) d_req = 1'b0;
    if (!i_req && $urandom_range(0, 2) == 0) begin
      i_req  = 1'b1;
      i_addr = {$urandom, $urandom};
    end
    if (!d_req && $urandom_range(0, 2) == 0) begin
      d_req   = 1'b1;
      d_we    = 1'($urandom_range(0, 1));
      d_wstrb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      d_addr  = {$urandom, $urandom};
      d_wdata = {$urandom, $urandom};
    end
    m_gnt    = 1'($urandom_range(0, 1));
    m_rvalid = ($urandom_range(0, 2) == 0);
    m_rdata  = {$urandom, $urandom};
    resetn   = ($urandom_range(0, 99) != 0);
  endtask

  task automatic tie_run(input int n_grants);
    int cyc;
    resetn = 1'b0; quiet_inputs();
    step();
    resetn = 1'b1;
    dut_log.delete();
    i_req = 1'b1; i_addr = 64'h4000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h5000;
    m_gnt = 1'b1; m_rvalid = 1'b1; m_rdata = 64'hABCD;
    cyc = 0;
    while (dut_log.size() < n_grants && cyc < 40) begin
      step();
      cyc++;
    end
    check_word("tie_grant_count", 64'(dut_log.size()), 64'(n_grants));
  endtask

  initial begin
    int count;
    resetn = 1'b0;
    i_addr = 64'h0; d_addr = 64'h0; d_wdata = 64'h0;
    quiet_inputs();
    @(negedge soc_clk);

    // Reset holds everything quiet even with every request and response asserted.
    i_req = 1'b1; d_req = 1'b1; m_rvalid = 1'b1;
    check_output();
    check_bit("rst_i_gnt", i_gnt, 1'b0);
    check_bit("rst_d_gnt", d_gnt, 1'b0);
    check_bit("rst_m_req", m_req, 1'b0);
    advance();
    step();

    // Spurious response while idle with nobody requesting.
    resetn = 1'b1; quiet_inputs(); m_rvalid = 1'b1;
    check_output();
    check_bit("spur_i_rvalid", i_rvalid, 1'b0);
    check_bit("spur_d_rvalid", d_rvalid, 1'b0);
    check_bit("spur_m_req", m_req, 1'b0);
    advance();
    m_rvalid = 1'b0;
    check_output();
    check_bit("spur_m_req_after", m_req, 1'b0);
    advance();

    // Single fetch: grant, issue, wait, response.
    i_req = 1'b1; i_addr = 64'h8000_0000; m_gnt = 1'b1;
    check_output();
    check_bit("f_c0_i_gnt", i_gnt, 1'b1);
    advance();
    i_req = 1'b0;
    check_output();
    check_bit("f_c1_m_req", m_req, 1'b1);
    check_word("f_c1_m_addr", m_addr, 64'h8000_0000);
    check_word("f_c1_m_wstrb", {56'h0, m_wstrb}, 64'h0);
    advance();
    m_gnt = 1'b0;
    check_output();
    check_bit("f_c2_m_req", m_req, 1'b0);
    advance();
    m_rvalid = 1'b1; m_rdata = 64'h0000_0000_0000_0013;
    check_output();
    check_bit("f_c3_i_rvalid", i_rvalid, 1'b1);
    check_word("f_c3_i_rdata", i_rdata, 64'h13);
    check_bit("f_c3_d_rvalid", d_rvalid, 1'b0);
    advance();
    quiet_inputs();

    // Tie breaking with both ports held high.
`ifdef MEM_ARB_ROUND_ROBIN_EN
    tie_run(4);
    if (dut_log.size() == 4) begin
      check_bit("tie_g0", dut_log[0], 1'b1);
      check_bit("tie_g1", dut_log[1], 1'b0);
      check_bit("tie_g2", dut_log[2], 1'b1);
      check_bit("tie_g3", dut_log[3], 1'b0);
    end
`else
    tie_run(3);
    if (dut_log.size() == 3) begin
      check_bit("tie_g0", dut_log[0], 1'b1);
      check_bit("tie_g1", dut_log[1], 1'b1);
      check_bit("tie_g2", dut_log[2], 1'b1);
    end
`endif
    quiet_inputs(); m_gnt = 1'b1; m_rvalid = 1'b1;
    for (int k = 0; k < 3; k++) step();
    quiet_inputs();
    step();

    // Write stalled by memory for five cycles.
    d_req = 1'b1; d_we = 1'b1; d_wstrb = 8'h0F; d_addr = 64'h1000; d_wdata = 64'h1122_3344;
    check_output();
    check_bit("w_d_gnt", d_gnt, 1'b1);
    advance();
    d_req = 1'b0;
    count = 0;
    for (int k = 0; k < 5; k++) begin
      check_output();
      if (m_req) count++;
      advance();
    end
    m_gnt = 1'b1;
    check_output();
    if (m_req) count++;
    check_word("w_m_addr", m_addr, 64'h1000);
    check_word("w_m_wdata", m_wdata, 64'h1122_3344);
    check_word("w_m_wstrb", {56'h0, m_wstrb}, 64'h0F);
    check_bit("w_m_we", m_we, 1'b1);
    advance();
    check_word("w_m_req_cycles", 64'(count), 64'd6);
    m_gnt = 1'b0; m_rvalid = 1'b1;
    check_output();
    check_bit("w_d_rvalid", d_rvalid, 1'b1);
    check_bit("w_i_rvalid", i_rvalid, 1'b0);
    advance();
    quiet_inputs();

    // Reset while waiting for a response abandons the transaction.
    i_req = 1'b1; i_addr = 64'h2000; m_gnt = 1'b1;
    step();
    i_req = 1'b0;
    step();
    m_gnt = 1'b0; resetn = 1'b0;
    step();
    resetn = 1'b1; m_rvalid = 1'b1; i_req = 1'b1; i_addr = 64'h3000;
    check_output();
    check_bit("rw_i_rvalid", i_rvalid, 1'b0);
    check_bit("rw_d_rvalid", d_rvalid, 1'b0);
    check_bit("rw_i_gnt", i_gnt, 1'b1);
    advance();
    i_req = 1'b0; m_rvalid = 1'b0;
    exp_i_gnt = 1'b0; exp_d_gnt = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      apply_stimulus();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
